// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

  // One state per control step of the multi-cycle datapath
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // What the current state asks the ALU decoder for
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000110;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - maps state class, opcode and funct to an ALU op code
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] aluop_o,
  output logic       funct_illegal_o
);

  // Unknown funct falls back to ADD so the datapath sees a defined op while illegal is flagged
  always_comb begin
    aluop_o         = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (cls_i)
      CLS_ADD: aluop_o = ALU_ADD;
      CLS_SUB: aluop_o = ALU_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          FN_ADD:  aluop_o = ALU_ADD;
          FN_SUB:  aluop_o = ALU_SUB;
          FN_AND:  aluop_o = ALU_AND;
          FN_OR:   aluop_o = ALU_OR;
          FN_XOR:  aluop_o = ALU_XOR;
          default: funct_illegal_o = 1'b1;
        endcase
      end
      CLS_ITYPE: begin
        case (opcode_i)
          OP_ADDI: aluop_o = ALU_ADD;
          OP_ANDI: aluop_o = ALU_AND;
          OP_ORI:  aluop_o = ALU_OR;
          OP_XORI: aluop_o = ALU_XOR;
          default: aluop_o = ALU_ADD;
        endcase
      end
      default: aluop_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multi-cycle MIPS datapath
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       lt,
  input  logic       gt,
  output logic [3:0] aluoperation,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       illegal,
  output logic       instr_done
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  alu_cls_e   alu_cls;
  logic       funct_illegal;

  alu_op_decoder u_alu_op_decoder (
    .cls_i           (alu_cls),
    .opcode_i        (opcode_q),
    .funct_i         (funct),
    .aluop_o         (aluoperation),
    .funct_illegal_o (funct_illegal)
  );

  // State and latched opcode registers; reset returns to FETCH from anywhere
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'b000000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state and Moore outputs; BRANCH pc_write follows the ALU flags directly
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    alu_cls    = CLS_ADD;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALU;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        opcode_d  = opcode;
        case (opcode)
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE, OP_BLT, OP_BGT:   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_cls   = CLS_RTYPE;
        if (funct_illegal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cls   = CLS_ITYPE;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_cls    = CLS_SUB;
        pc_src     = PC_SRC_ALUOUT;
        instr_done = 1'b1;
        case (opcode_q)
          OP_BEQ:  pc_write = zero;
          OP_BNE:  pc_write = ~zero;
          OP_BLT:  pc_write = lt;
          OP_BGT:  pc_write = gt;
          default: pc_write = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, lt, gt;
  logic [3:0] aluoperation;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write, iord, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal, instr_done;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .lt           (lt),
    .gt           (gt),
    .aluoperation (aluoperation),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .illegal      (illegal),
    .instr_done   (instr_done)
  );

  always #5 clk = ~clk;

  // Observed control word: op, pcw, pcsrc, irw, iord, mr, mw, m2r, rdst, rw, asa, asb, ill, done
  logic [18:0] obs;
  assign obs = {aluoperation, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, illegal, instr_done};

  function automatic logic [18:0] mk(input logic [3:0] op, input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic io, input logic mr, input logic mw,
                                     input logic m2r, input logic rd, input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic ill, input logic done);
    return {op, pcw, pcs, irw, io, mr, mw, m2r, rd, rw, asa, asb, ill, done};
  endfunction

  function automatic logic [18:0] fetch_word();
    return mk(4'b0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: list of expected control words for one instruction, FETCH first
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic l,
                       input logic g, output logic [18:0] q[$]);
    logic [3:0] fop;
    logic       fok;
    logic       taken;
    q = {};
    q.push_back(fetch_word());
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101, 6'b001110,
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000010:
        q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0));
      default: begin
        q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0));
        return;
      end
    endcase
    case (op)
      6'b000000: begin
        fok = 1'b1;
        case (fn)
          6'b100000: fop = 4'd0;
          6'b100010: fop = 4'd1;
          6'b100100: fop = 4'd2;
          6'b100101: fop = 4'd3;
          6'b100110: fop = 4'd4;
          default: begin fop = 4'd0; fok = 1'b0; end
        endcase
        q.push_back(mk(fop, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, !fok, 0));
        if (fok) q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 1));
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110: begin
        fop = (op == 6'b001000) ? 4'd0 : (op == 6'b001100) ? 4'd2 : (op == 6'b001101) ? 4'd3 : 4'd4;
        q.push_back(mk(fop, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
        q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 1));
      end
      6'b100011: begin
        q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
        q.push_back(mk(4'd0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
        q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 1));
      end
      6'b101011: begin
        q.push_back(mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
        q.push_back(mk(4'd0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 1));
      end
      6'b000010:
        q.push_back(mk(4'd0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
      default: begin
        taken = (op == 6'b000100) ? z : (op == 6'b000101) ? !z : (op == 6'b000110) ? l : g;
        q.push_back(mk(4'd1, taken, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1));
      end
    endcase
  endtask

  // Runs one instruction starting #1 after the edge that entered FETCH.
  // Opcode is scrambled after DECODE and funct after EXEC_R to show they are not re-sampled.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic l, input logic g, input string tag);
    logic [18:0] q[$];
    build(op, fn, z, l, g, q);
    for (int c = 0; c < q.size(); c++) begin
      opcode = (c <= 1) ? op : 6'($urandom);
      funct  = (c <= 2) ? fn : 6'($urandom);
      zero = z; lt = l; gt = g;
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, c), q[c]);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] legal_ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100, 6'b001101,
                                 6'b001110, 6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000010};
  logic [5:0] legal_fns [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};

  initial begin
    logic [5:0] rop, rfn;
    rst = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; lt = 1'b0; gt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_fetch", fetch_word());
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b000000, 6'b100110, 0, 0, 0, "xor");
    run_instr(6'b100011, 6'b000000, 0, 0, 0, "lw");
    run_instr(6'b000100, 6'b000000, 1, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 0, 0, 0, "beq_not");
    run_instr(6'b000110, 6'b000000, 0, 1, 0, "blt_taken");
    run_instr(6'b000111, 6'b000000, 0, 0, 0, "bgt_not");
    run_instr(6'b111111, 6'b000000, 0, 0, 0, "illegal_op");
    run_instr(6'b000000, 6'b000000, 0, 0, 0, "illegal_fn");
    run_instr(6'b101011, 6'b000000, 0, 0, 0, "sw");
    run_instr(6'b000010, 6'b000000, 0, 0, 0, "j");

    // Reset asserted during MEM_RD of a lw
    opcode = 6'b100011;
    @(negedge clk); check("rstlw_fetch", fetch_word());
    @(posedge clk); #1;
    @(negedge clk); check("rstlw_decode", mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0));
    @(posedge clk); #1;
    @(negedge clk); check("rstlw_addr", mk(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); check("rstlw_memrd", mk(4'd0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    @(posedge clk); #1;
    @(negedge clk); check("rstlw_after", fetch_word());
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(6'b001101, 6'b000000, 0, 0, 0, "ori_after_rst");

    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
      rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
      run_instr(rop, rfn, 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    check("final_fetch", fetch_word());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
